// File: rtl/bias_pkg.sv
// -----------------------------------------------------------------------------
// bias_pkg
// Shared types for the bias PE sequencer: the fixed_16 datapath type, the
// sequencer state encoding, the default writeback clamp limit and the clamp
// helper used when the design is built with BIAS_CLAMP_EN defined.
// -----------------------------------------------------------------------------
package bias_pkg;

    // Q-format bias / sum value as seen by the PE.
    typedef logic signed [15:0] fixed_16;

    // Sequencer states. DONE is decoded from the final retire rather than
    // held as a resident state; it is kept in the encoding as a safe exit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Default symmetric clamp bound for written-back biases.
    localparam fixed_16 BIAS_LIMIT_DEFAULT = 16'sh4000;

    // Signed saturation of a written-back bias to [-limit, +limit].
    function automatic fixed_16 clamp_bias(input fixed_16 value, input fixed_16 limit);
        fixed_16 neg_limit;
        neg_limit = -limit;
        if (value > limit) begin
            return limit;
        end
        if (value < neg_limit) begin
            return neg_limit;
        end
        return value;
    endfunction

endpackage

// File: rtl/bias_tag_pipe.sv
// -----------------------------------------------------------------------------
// bias_tag_pipe
// DEPTH-deep shift register of {idx, valid} tags that tracks each operand set
// through the fixed-latency PE. Advances only when ce_i is high so it stays in
// lock-step with a clock-enabled PE; synchronous active-high reset empties it.
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   ce_i          clock enable; the pipe holds when low
//   push_valid_i  tag valid for the operand issued this cycle
//   push_idx_i    neuron index of the operand issued this cycle
//   pop_valid_o   tag valid at the PE result point
//   pop_idx_o     neuron index at the PE result point
// -----------------------------------------------------------------------------
module bias_tag_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             push_valid_i,
    input  logic [IDX_W-1:0] push_idx_i,
    output logic             pop_valid_o,
    output logic [IDX_W-1:0] pop_idx_o
);

    logic             valid_q [DEPTH];
    logic [IDX_W-1:0] idx_q   [DEPTH];

    // Stage 0 takes the new tag (an invalid tag for a bubble); later stages shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '{default: 1'b0};
            idx_q   <= '{default: '0};
        end else if (ce_i) begin
            valid_q[0] <= push_valid_i;
            idx_q[0]   <= push_idx_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign pop_valid_o = valid_q[DEPTH-1];
    assign pop_idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/bias_pe_sched.sv
// -----------------------------------------------------------------------------
// bias_pe_sched
// Time-shares one bias PE across NUM_NEURONS neurons. Holds the per-neuron
// bias file, issues each accepted (sum_in, delta_k) pair to the PE together
// with that neuron's bias, retires net_sum to the output stream PE_LAT cycles
// later and, in training passes, writes bias_change back into the bias file.
// HLS-style ap_start / ap_done / ap_idle / ap_ready control with ap_ce.
//
// Build option: BIAS_CLAMP_EN
//   defined   - parameter BIAS_LIMIT; writebacks are signed-clamped to
//               [-BIAS_LIMIT, +BIAS_LIMIT] and clamp_hit pulses on each
//               clamped write.
//   undefined - pe_bias_change is written unmodified; no clamp_hit port.
//
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset (wins over ap_ce)
//   ap_ce               clock enable; every register holds while low
//   ap_start            start a pass (sampled in IDLE)
//   ap_done, ap_ready   one-cycle pulse with the retire of the last neuron
//   ap_idle             high while IDLE
//   training, eta       pass mode and learning rate, latched on start
//   load_valid/idx/data bias-file write port, honoured only in IDLE
//   in_valid/in_ready   input pair handshake; sum_in, delta_k payload
//   pe_*                operand bus to the PE and its results
//   out_valid/idx/net_sum  retire stream, no backpressure
// -----------------------------------------------------------------------------
module bias_pe_sched
    import bias_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned PE_LAT      = 1,
    parameter int unsigned IDX_W       = 4
`ifdef BIAS_CLAMP_EN
    ,
    parameter fixed_16     BIAS_LIMIT  = BIAS_LIMIT_DEFAULT
`endif
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_ce,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic             training,
    input  logic [15:0]      eta,
    input  logic             load_valid,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [15:0]      load_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      sum_in,
    input  logic [15:0]      delta_k,
    output logic             pe_issue,
    output logic [15:0]      pe_init_bias,
    output logic [15:0]      pe_sum_in,
    output logic [15:0]      pe_delta_k,
    output logic [15:0]      pe_eta,
    input  logic [15:0]      pe_net_sum,
    input  logic [15:0]      pe_bias_change,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [15:0]      out_net_sum
`ifdef BIAS_CLAMP_EN
    ,
    output logic             clamp_hit
`endif
);

    // issue_cnt must be able to hold NUM_NEURONS itself, hence one extra bit.
    localparam int unsigned       CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(NUM_NEURONS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic              training_q;
    logic [15:0]       eta_q;
    fixed_16           bias_q [NUM_NEURONS];

    logic              cnt_open;
    logic              accept;
    logic              tag_valid;
    logic [IDX_W-1:0]  tag_idx;
    logic [IDX_W-1:0]  issue_idx;
    logic              retire;
    logic              last_retire;
    logic              load_ok;
    logic              wb_en;
    fixed_16           wb_value;

    // ---- issue side --------------------------------------------------------

    assign issue_idx = issue_cnt_q[IDX_W-1:0];
    assign cnt_open  = (state_q == RUN) && (issue_cnt_q < CNT_MAX);

    // Gated by ap_ce so no pair is consumed while the block is frozen.
    assign in_ready = ap_ce && cnt_open;
    assign accept   = in_ready && in_valid;

    // Operands are forwarded in the acceptance cycle and zeroed otherwise.
    assign pe_issue     = accept;
    assign pe_init_bias = accept ? bias_q[issue_idx] : 16'h0000;
    assign pe_sum_in    = accept ? sum_in            : 16'h0000;
    assign pe_delta_k   = accept ? delta_k           : 16'h0000;
    assign pe_eta       = eta_q;

    // ---- tag pipe: tracks which neuron each PE result belongs to ----------

    bias_tag_pipe #(
        .DEPTH (PE_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk_i        (ap_clk),
        .rst_i        (ap_rst),
        .ce_i         (ap_ce),
        .push_valid_i (accept),
        .push_idx_i   (issue_idx),
        .pop_valid_o  (tag_valid),
        .pop_idx_o    (tag_idx)
    );

    // ---- retire side -------------------------------------------------------

    // A frozen pipe presents nothing; the same tag retires once ap_ce returns.
    assign retire      = ap_ce && tag_valid;
    assign last_retire = retire && (tag_idx == IDX_LAST);

    assign out_valid   = retire;
    assign out_idx     = retire ? tag_idx    : '0;
    assign out_net_sum = retire ? pe_net_sum : 16'h0000;

    assign ap_done  = last_retire;
    assign ap_ready = last_retire;
    assign ap_idle  = (state_q == IDLE);

    // ---- bias file write sources ------------------------------------------

    assign load_ok = (state_q == IDLE) && load_valid && ({1'b0, load_idx} < CNT_MAX);
    assign wb_en   = retire && training_q;

`ifdef BIAS_CLAMP_EN
    assign wb_value  = clamp_bias(fixed_16'(pe_bias_change), BIAS_LIMIT);
    assign clamp_hit = wb_en && (wb_value != fixed_16'(pe_bias_change));
`else
    assign wb_value  = fixed_16'(pe_bias_change);
`endif

    // ---- sequencer state, latched pass controls and bias file ------------

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            training_q  <= 1'b0;
            eta_q       <= 16'h0000;
            bias_q      <= '{default: '0};
        end else if (ap_ce) begin
            case (state_q)
                IDLE: begin
                    // A load coinciding with ap_start lands before the pass reads it.
                    if (load_ok) begin
                        bias_q[load_idx] <= fixed_16'(load_data);
                    end
                    if (ap_start) begin
                        training_q  <= training;
                        eta_q       <= eta;
                        issue_cnt_q <= '0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                        if (issue_cnt_q == CNT_LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_retire) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Each index issues once per pass, so a writeback never races a
            // read of the same entry; it is placed last so it wins any overlap.
            if (wb_en) begin
                bias_q[tag_idx] <= wb_value;
            end
        end
    end

endmodule

// File: doc/bias_pe_sched.md
Name: bias_pe_sched

Overview:
- Sequencer that time-shares one bias PE across NUM_NEURONS neurons of a layer.
- Holds the layer's bias file (one fixed_16 per neuron) and accepts a stream of (sum_in, delta_k) pairs, one per neuron in index order.
- Issues each pair to the PE with that neuron's stored bias, retires net_sum to the output stream, and in training passes writes bias_change back into the bias file.
- Sits between the layer's accumulator stage and the activation stage; uses HLS-style ap_start/ap_done control.

Parameters:
- NUM_NEURONS, 16, number of neurons (bias entries) per pass; >=1.
- PE_LAT, 1, fixed PE latency in cycles from pe_issue to pe result valid; >=1.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_NEURONS.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  reset
- ap_ce  in  1  clock enable; all state holds when low
- ap_start  in  1  begin one pass; sampled in IDLE
- ap_done  out  1  one-cycle pulse when last result retires
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  one-cycle pulse, same cycle as ap_done
- training  in  1  pass mode; latched on accepted ap_start
- eta  in  16  learning rate; latched on accepted ap_start
- load_valid  in  1  bias-file write strobe; honoured only in IDLE
- load_idx  in  IDX_W  bias-file write index
- load_data  in  16  bias-file write data
- in_valid  in  1  input pair valid
- in_ready  out  1  input pair accepted when in_valid && in_ready
- sum_in  in  16  accumulated weighted sum
- delta_k  in  16  error term
- pe_issue  out  1  PE operands valid this cycle
- pe_init_bias  out  16  stored bias of issued neuron
- pe_sum_in  out  16  forwarded sum_in
- pe_delta_k  out  16  forwarded delta_k
- pe_eta  out  16  latched eta
- pe_net_sum  in  16  PE net_sum result, valid PE_LAT cycles after pe_issue
- pe_bias_change  in  16  PE updated bias, same timing as pe_net_sum
- out_valid  out  1  net_sum result valid
- out_idx  out  IDX_W  neuron index of result
- out_net_sum  out  16  net_sum result

Behaviour:
- Reset, synchronous and active-high on ap_rst at posedge ap_clk; takes priority over ap_ce.
  - State goes to IDLE; counters and the PE_LAT-deep tag pipe clear.
  - Bias file clears to 0; training and eta clear to 0.
  - All outputs 0 except ap_idle=1.
- With ap_ce=0, every register holds, including a pulse in progress.
- IDLE:
  - ap_idle=1.
  - load_valid writes bias[load_idx]=load_data; an index >= NUM_NEURONS is ignored.
  - On ap_start, latch training and eta, clear issue_cnt, and go to RUN. ap_start and load_valid in the same cycle: the load is performed, then the pass starts.
  - In any state other than IDLE, load_valid is ignored.
- RUN:
  - in_ready = (issue_cnt < NUM_NEURONS).
  - On acceptance, in the same cycle: pe_issue=1, pe_init_bias=bias[issue_cnt], sum_in/delta_k forwarded combinationally, pe_eta=latched eta. Also push tag {issue_cnt, 1} into the tag pipe and increment issue_cnt.
  - Bubbles (in_valid=0) push an invalid tag.
  - When issue_cnt reaches NUM_NEURONS, go to DRAIN.
- DRAIN: in_ready=0; bubbles shift through the pipe.
- Retire, in any state, when the tag pipe output is valid:
  - out_valid=1, out_idx=tag idx, out_net_sum=pe_net_sum.
  - If training is latched, bias[tag idx] <= pe_bias_change; inference passes leave the bias file unchanged.
  - The output is a registered-free pass-through with no backpressure; the downstream must always accept.
- DONE: when the retire of index NUM_NEURONS-1 occurs, ap_done=ap_ready=1 for that cycle; next state is IDLE.
- Hazards: each index is issued once per pass, so no read-after-writeback hazard exists. The pass-N writeback is complete before any pass N+1 issue.
- Reset mid-pass: pipe contents are discarded and no further writebacks occur.
- NUM_NEURONS=1: a single accept, then DRAIN for PE_LAT cycles, then the done pulse.
- Latency: first out_valid PE_LAT cycles after first acceptance. Full pass with in_valid held high is NUM_NEURONS+PE_LAT cycles from the RUN entry.

Optional Feature:
- Macro BIAS_CLAMP_EN.
- Defined: adds parameter BIAS_LIMIT (default 16'sh4000). The writeback value is signed-clamped to [-BIAS_LIMIT, +BIAS_LIMIT]; output port clamp_hit pulses on each clamped write.
- Undefined: pe_bias_change is written unmodified and clamp_hit does not exist.

Decomposition:
- Shared package bias_pkg holds:
  - fixed_16 typedef (16-bit signed)
  - the state enum {IDLE, RUN, DRAIN, DONE}
  - BIAS_LIMIT default
- One natural sub-module: bias_tag_pipe, the PE_LAT-deep shift register of {idx, valid} gated by ap_ce.

Test Plan:
- Load bias[0..3]={1,2,3,4}, NUM_NEURONS=4, training=0, stream sum_in={10,20,30,40}, with a stub PE giving net_sum=bias+sum_in after PE_LAT=1 -> out_net_sum={11,22,33,44}, idx 0..3, ap_done at cycle 5 after RUN entry, bias file unchanged.
- Same setup with training=1 and stub bias_change=bias-1 -> second pass pe_init_bias={0,1,2,3}.
- in_valid toggling 1,0,1,0 -> out_valid carries the same gaps, indices stay in order, ap_done only after idx 3.
- ap_ce low for 3 cycles mid-RUN -> no issues, retires or counter changes; the pass resumes with identical results.
- ap_rst asserted during DRAIN -> the next cycle shows ap_idle=1, no out_valid, and a read of the bias file through a new pass gives pe_init_bias=0.
- With BIAS_CLAMP_EN, stub bias_change=16'sh7000 -> stored 16'sh4000 and clamp_hit=1.
